// File: rtl/saus_input_loader.sv
// Collects a row of signed residual samples, LANES per beat, into a zero-padded
// MAX_N-entry vector and holds it for the decomposition stage until it is consumed.
module saus_input_loader #(
    parameter int WIDTH = 16,
    parameter int MAX_N = 32,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [1:0]               in_size,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAX_N*WIDTH-1:0]   out_vector,
    output logic [1:0]               out_size,
    output logic                     size_err
);

    localparam int BEATS_MAX = MAX_N / LANES;
    localparam int CNTW      = $clog2(BEATS_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                   state_r;
    logic [CNTW-1:0]          cnt_r;
    logic [CNTW-1:0]          beats_r;
    logic [MAX_N*WIDTH-1:0]   buf_r;

    logic [31:0]              n_s;
    logic                     bad_s;
    logic [CNTW-1:0]          beats_s;
    logic [CNTW-1:0]          cnt_nxt_s;

    assign out_vector = buf_r;

    // Decode the row length; unsupported lengths fall back to a full MAX_N row.
    always_comb begin
        n_s       = 32'd4 << in_size;
        bad_s     = (n_s < 32'(LANES)) || (n_s > 32'(MAX_N));
        cnt_nxt_s = cnt_r + CNTW'(1);
        if (bad_s) begin
            beats_s = CNTW'(BEATS_MAX);
        end else begin
            beats_s = CNTW'(n_s / 32'(LANES));
        end
    end

    // Row assembly FSM; in_ready/out_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            beats_r   <= '0;
            buf_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_size  <= 2'd0;
            size_err  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        out_size <= in_size;
                        size_err <= size_err | bad_s;
                        beats_r  <= beats_s;
                        cnt_r    <= CNTW'(1);
                        // Clear the whole buffer so a short row never exposes stale samples.
                        buf_r    <= '0;
                        for (int l = 0; l < LANES; l++) begin
                            buf_r[l*WIDTH +: WIDTH] <= in_data[l*WIDTH +: WIDTH];
                        end
                        if (beats_s == CNTW'(1)) begin
                            state_r   <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state_r   <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        for (int l = 0; l < LANES; l++) begin
                            buf_r[(int'(cnt_r)*LANES + l)*WIDTH +: WIDTH] <= in_data[l*WIDTH +: WIDTH];
                        end
                        cnt_r <= cnt_nxt_s;
                        if (cnt_nxt_s == beats_r) begin
                            state_r   <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        cnt_r     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saus_input_loader.sv
// Self-checking bench for saus_input_loader: a table of row recipes plus
// hand-written reset sequences, with expected rows kept in a scoreboard queue.
module tb_saus_input_loader;

    localparam int WIDTH = 16;
    localparam int MAX_N = 32;
    localparam int LANES = 4;
    localparam int VW    = MAX_N * WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [1:0]             in_size;
    logic                   out_valid;
    logic                   out_ready;
    logic [VW-1:0]          out_vector;
    logic [1:0]             out_size;
    logic                   size_err;

    saus_input_loader #(.WIDTH(WIDTH), .MAX_N(MAX_N), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_size    (in_size),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .out_size   (out_size),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    // size: code driven; n: expected row length; sample i = base + step*i
    typedef struct {
        logic [1:0] size;
        int         n;
        int         base;
        int         step;
        int         gap;
        int         hold;
        bit         same_prev;
    } row_t;

    typedef struct {
        logic [VW-1:0] vec;
        logic [1:0]    size;
    } exp_t;

    exp_t          sb[$];
    row_t          rows[8];
    logic [VW-1:0] prev_vec;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] build_vec(input row_t r);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < r.n; i++) begin
            v[i*WIDTH +: WIDTH] = WIDTH'(r.base + r.step * i);
        end
        return v;
    endfunction

    task automatic drive_beat(input logic [1:0] sz, input logic [LANES*WIDTH-1:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_size  = sz;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Drives up to max_beats beats of a row and pushes its expected result.
    task automatic send_row(input row_t r, input int max_beats);
        exp_t                   e;
        logic [VW-1:0]          v;
        logic [LANES*WIDTH-1:0] d;
        int                     nb;
        v      = build_vec(r);
        e.vec  = v;
        e.size = r.size;
        sb.push_back(e);
        nb = r.n / LANES;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            d = v[b*LANES*WIDTH +: LANES*WIDTH];
            drive_beat(r.size, d);
            if (b != nb - 1) begin
                repeat (r.gap) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic run_row(input row_t r);
        exp_t e;
        out_ready = (r.hold == 0);
        send_row(r, 99);
        chk("out_valid_latency", VW'(out_valid), VW'(1));
        chk("in_ready_hold", VW'(in_ready), VW'(0));
        for (int k = 0; k < r.hold; k++) begin
            in_valid = 1'b1;
            in_size  = ~r.size;
            in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("hold_out_valid", VW'(out_valid), VW'(1));
            chk("hold_in_ready", VW'(in_ready), VW'(0));
            chk("hold_vector", out_vector, sb[0].vec);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("out_vector", out_vector, e.vec);
            chk("out_size", VW'(out_size), VW'(e.size));
        end
        if (r.same_prev) chk("gapped_vs_gapfree", out_vector, prev_vec);
        prev_vec = out_vector;
        @(posedge clk); #1;
        chk("release_out_valid", VW'(out_valid), VW'(0));
        chk("release_in_ready", VW'(in_ready), VW'(1));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, VW'(out_valid), VW'(0));
        chk({tag, "_out_vector"}, out_vector, VW'(0));
        chk({tag, "_out_size"}, VW'(out_size), VW'(0));
        chk({tag, "_size_err"}, VW'(size_err), VW'(0));
        chk({tag, "_in_ready"}, VW'(in_ready), VW'(1));
    endtask

    initial begin
        row_t r;
        rows[0] = '{2'd3, 32, 1, 1, 0, 0, 1'b0};
        rows[1] = '{2'd1, 8, -1, -1, 0, 0, 1'b0};
        rows[2] = '{2'd3, 32, 100, 3, 0, 0, 1'b0};
        rows[3] = '{2'd0, 4, 7, -2, 0, 0, 1'b0};
        rows[4] = '{2'd2, 16, -500, 37, 3, 0, 1'b0};
        rows[5] = '{2'd2, 16, -500, 37, 0, 0, 1'b1};
        rows[6] = '{2'd1, 8, 32767, -1, 0, 5, 1'b0};
        rows[7] = '{2'd0, 4, -32768, 1, 1, 0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = 2'd0;
        out_ready = 1'b0;
        prev_vec  = '0;
        #12;
        chk_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_row(rows[i]);
        end

        // Reset after 3 of 8 beats discards the partial row.
        r = '{2'd3, 32, 900, 5, 0, 0, 1'b0};
        out_ready = 1'b1;
        send_row(r, 3);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("mid_fill_reset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_row('{2'd3, 32, -1000, 61, 0, 0, 1'b0});

        // Reset while a row is held drops out_valid at once.
        out_ready = 1'b0;
        send_row('{2'd1, 8, 11, 11, 0, 0, 1'b0}, 99);
        chk("held_before_reset", VW'(out_valid), VW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("mid_hold_reset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_row('{2'd0, 4, 3, 3, 0, 0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/saus_input_loader.md
SAUS_INPUT_LOADER -- requirements
Module: saus_input_loader

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each signed residual sample.
REQ-002 Parameter MAX_N, default 32: output vector length, i.e. largest supported transform size.
REQ-003 Parameter LANES, default 4: samples accepted per input beat; MAX_N SHALL be a multiple of LANES.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port in_valid  input  1: an input beat is present.
REQ-007 Port in_ready  output  1: the block accepts a beat this cycle.
REQ-008 Port in_data  input  LANES x WIDTH signed: samples of the beat; lane 0 is the lowest row index.
REQ-009 Port in_size  input  2: row length code, 0->4, 1->8, 2->16, 3->32; sampled only on the first beat of a row.
REQ-010 Port out_valid  output  1: out_vector holds a complete row.
REQ-011 Port out_ready  input  1: the downstream decomposition stage consumes the row.
REQ-012 Port out_vector  output  MAX_N x WIDTH signed: the assembled row, feeding the decomposition stage input_vector.
REQ-013 Port out_size  output  2: latched size code of the held row.
REQ-014 Port size_err  output  1: sticky flag, set when a row's size code requests fewer samples than LANES or more than MAX_N.

Function
REQ-015 FSM states: IDLE (no row in progress), FILL (row partially received), HOLD (row complete, presented downstream).
REQ-016 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-017 in_ready SHALL be 1 in IDLE and FILL and 0 in HOLD.
REQ-018 In IDLE, an accepted beat latches in_size into out_size, zeroes all MAX_N buffer entries, writes lanes to positions 0..LANES-1, and sets beat counter to 1.
REQ-019 In FILL, an accepted beat writes lanes to positions cnt*LANES .. cnt*LANES+LANES-1 and increments cnt.
REQ-020 Beats per row = N/LANES, where N is the decoded size; the beat making cnt equal N/LANES moves the FSM to HOLD, from IDLE or from FILL.
REQ-021 When N/LANES = 1, the first beat moves IDLE directly to HOLD.
REQ-022 Buffer positions at N and above SHALL read zero while out_valid is 1.
REQ-023 out_valid SHALL be 1 exactly in HOLD; latency from the last accepted beat to out_valid is 1 cycle.
REQ-024 out_vector and out_size SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 In HOLD with out_ready=1, the FSM goes to IDLE on that edge; in_ready rises the next cycle (no same-cycle pass-through).
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 in_valid=0 in FILL holds cnt and buffer unchanged for any number of cycles.
REQ-028 If the decoded N is below LANES or above MAX_N (possible for non-default parameters), the row is treated as N=MAX_N and size_err is set; it stays set until reset.
REQ-029 Arithmetic: no sample modification; samples are stored bit-exact and sign is preserved.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately, asynchronously, force state IDLE, cnt=0, out_valid=0, out_size=0, size_err=0, and all out_vector entries 0; in_ready is 1 while reset is released.
REQ-031 Reset asserted mid-FILL or mid-HOLD SHALL discard the partial or held row; the first accepted beat after release starts a new row.

Verification
REQ-032 N=32, 8 back-to-back beats of samples 1..32, out_ready=1 -> out_valid one cycle after beat 8; out_vector[i]=i+1; out_size=3; in_ready low for exactly one cycle.
REQ-033 N=8, 2 beats of samples -1..-8 -> out_vector[0..7]=-1..-8 and out_vector[8..31]=0; a following N=32 row does not inherit stale values.
REQ-034 N=4, single beat -> IDLE to HOLD in one accepted beat; out_valid the next cycle.
REQ-035 Row complete, out_ready=0 for 5 cycles -> out_valid and out_vector stable, in_ready=0, and in_valid beats are ignored; out_ready=1 -> out_valid drops the next cycle.
REQ-036 N=16, in_valid gapped (beat, 3 idle cycles, beat ...) -> result identical to the gap-free case.
REQ-037 rst_n pulsed low after 3 of 8 beats -> all outputs 0 immediately; a fresh 8-beat row afterwards yields the correct vector.
